// File: rtl/lives_manager_if.sv
// ============================================================================
// Module  : lives_manager_if
// Brief   : Frame-rate request inputs and HUD/status outputs of lives_manager.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface lives_manager_if #(
  parameter int LIVES_W = 2
);
  logic               lose_life;
  logic               extralife;
  logic               powerup;
  logic [9:0]         LivesX;
  logic [9:0]         LivesY;
  logic [LIVES_W-1:0] lives_counter;
  logic               lose_game;
  logic               invuln;
  logic               life_lost;
  logic               lives_blink;

  modport master (
    output lose_life, extralife, powerup,
    input  LivesX, LivesY, lives_counter, lose_game, invuln, life_lost, lives_blink
  );

  modport slave (
    input  lose_life, extralife, powerup,
    output LivesX, LivesY, lives_counter, lose_game, invuln, life_lost, lives_blink
  );
endinterface

`default_nettype wire

// File: rtl/lives_manager.sv
// ============================================================================
// Module  : lives_manager
// Brief   : Per-frame player-lives tracker with saturating gain/loss, post-hit
//           immunity window and sticky game-over. Optional HUD icon blinking
//           during the window is built when LIVES_BLINK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lives_manager #(
  parameter int LIVES_W       = 2,
  parameter int MAX_LIVES     = 3,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 4,
  parameter int LIVES_X_UL    = 608,
  parameter int LIVES_Y_UL    = 17
) (
  input  wire logic       frame_clk,
  input  wire logic       Reset,
  lives_manager_if.slave  bus
);

  localparam int TIMER_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_INVULN    = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 lose_game_q, lose_game_d;
  logic                 invuln_q, invuln_d;
  logic                 life_lost_q, life_lost_d;
  logic                 blink_q, blink_d;
  logic                 gain;
  logic                 can_gain;

  assign gain     = bus.extralife & bus.powerup;
  assign can_gain = gain && (lives_q < LIVES_W'(MAX_LIVES));

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    timer_d     = timer_q;
    lose_game_d = lose_game_q;
    life_lost_d = 1'b0;
    case (state_q)
      ST_ALIVE: begin
        if (bus.lose_life) begin
          lives_d     = lives_q - 1'b1;
          life_lost_d = 1'b1;
          if (lives_q == LIVES_W'(1)) begin
            state_d     = ST_GAME_OVER;
            lose_game_d = 1'b1;
          end else if (INVULN_FRAMES > 0) begin
            state_d = ST_INVULN;
            timer_d = TIMER_W'(INVULN_FRAMES);
          end
        end else if (can_gain) begin
          lives_d = lives_q + 1'b1;
        end
      end
      ST_INVULN: begin
        if (can_gain) begin
          lives_d = lives_q + 1'b1;
        end
        // Leaving on the 1->0 edge keeps invuln high for exactly INVULN_FRAMES frames.
        if (timer_q <= TIMER_W'(1)) begin
          state_d = ST_ALIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_GAME_OVER: begin
        lives_d     = '0;
        lose_game_d = 1'b1;
      end
      default: begin
        state_d = ST_ALIVE;
      end
    endcase
    invuln_d = (state_d == ST_INVULN);
  end

`ifdef LIVES_BLINK_EN
  localparam int BCNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  always_comb begin
    blink_d = 1'b1;
    bcnt_d  = '0;
    if (state_d == ST_INVULN) begin
      if (state_q != ST_INVULN) begin
        blink_d = 1'b0;
      end else if (bcnt_q == BCNT_W'(BLINK_PERIOD - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end
`else
  always_comb begin
    blink_d = 1'b1;
  end
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_ALIVE;
      lives_q     <= LIVES_W'(START_LIVES);
      timer_q     <= '0;
      lose_game_q <= 1'b0;
      invuln_q    <= 1'b0;
      life_lost_q <= 1'b0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      lose_game_q <= lose_game_d;
      invuln_q    <= invuln_d;
      life_lost_q <= life_lost_d;
      blink_q     <= blink_d;
    end
  end

  assign bus.LivesX        = 10'(LIVES_X_UL);
  assign bus.LivesY        = 10'(LIVES_Y_UL);
  assign bus.lives_counter = lives_q;
  assign bus.lose_game     = lose_game_q;
  assign bus.invuln        = invuln_q;
  assign bus.life_lost     = life_lost_q;
  assign bus.lives_blink   = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_lives_manager.sv
// ============================================================================
// Module  : tb_lives_manager
// Brief   : Scoreboard bench for lives_manager (default build plus an
//           INVULN_FRAMES=0 instance).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lives_manager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lives_manager_if #(.LIVES_W(2)) b0 ();
  lives_manager_if #(.LIVES_W(2)) b1 ();

  lives_manager #(.LIVES_W(2), .MAX_LIVES(3), .START_LIVES(3), .INVULN_FRAMES(60),
                  .BLINK_PERIOD(4), .LIVES_X_UL(608), .LIVES_Y_UL(17))
    dut0 (.frame_clk(clk), .Reset(rst), .bus(b0.slave));

  lives_manager #(.LIVES_W(2), .MAX_LIVES(3), .START_LIVES(3), .INVULN_FRAMES(0),
                  .BLINK_PERIOD(4), .LIVES_X_UL(608), .LIVES_Y_UL(17))
    dut1 (.frame_clk(clk), .Reset(rst), .bus(b1.slave));

  // {LivesX, LivesY, lives, lose_game, invuln, life_lost, lives_blink}
  typedef struct {
    bit          sel;
    logic [25:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    b0.lose_life = 1'b0; b0.extralife = 1'b0; b0.powerup = 1'b0;
    b1.lose_life = 1'b0; b1.extralife = 1'b0; b1.powerup = 1'b0;
  end

  // Monitor: one expectation per frame edge, sampled 1 time unit after it.
  initial begin
    exp_t        e;
    logic [25:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel)
          got = {b1.LivesX, b1.LivesY, b1.lives_counter, b1.lose_game,
                 b1.invuln, b1.life_lost, b1.lives_blink};
        else
          got = {b0.LivesX, b0.LivesY, b0.lives_counter, b0.lose_game,
                 b0.invuln, b0.life_lost, b0.lives_blink};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s: got x=%0d y=%0d lives=%0d go=%b inv=%b lost=%b blink=%b, expected x=%0d y=%0d lives=%0d go=%b inv=%b lost=%b blink=%b",
                   e.name, got[25:16], got[15:6], got[5:4], got[3], got[2], got[1], got[0],
                   e.v[25:16], e.v[15:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  function automatic logic eb(input int k);
`ifdef LIVES_BLINK_EN
    return ((k / 4) % 2) == 1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic frame(input bit s, input logic r, input logic lose, input logic ext,
                       input logic pw, input logic [1:0] lv, input logic lg,
                       input logic inv, input logic ll, input logic bl, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    b0.lose_life = s ? 1'b0 : lose;
    b0.extralife = s ? 1'b0 : ext;
    b0.powerup   = s ? 1'b0 : pw;
    b1.lose_life = s ? lose : 1'b0;
    b1.extralife = s ? ext  : 1'b0;
    b1.powerup   = s ? pw   : 1'b0;
    e.sel  = s;
    e.v    = {10'd608, 10'd17, lv, lg, inv, ll, bl};
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic win(input int k0, input int k1, input logic lose, input logic ext,
                     input logic pw, input logic [1:0] lv, input string nm);
    for (int k = k0; k <= k1; k++)
      frame(1'b0, 1'b0, lose, ext, pw, lv, 1'b0, 1'b1, 1'b0, eb(k), nm);
  endtask

  initial begin
    frame(0, 1, 0, 0, 0, 2'd3, 0, 0, 0, 1, "reset");
    repeat (10) frame(0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 1, "idle");

    frame(0, 0, 1, 0, 0, 2'd2, 0, 1, 1, eb(0), "hit");
    win(1, 59, 1, 0, 0, 2'd2, "window_hold");
    frame(0, 0, 1, 0, 0, 2'd2, 0, 0, 0, 1, "window_end");

    frame(0, 0, 0, 1, 0, 2'd2, 0, 0, 0, 1, "gain_no_powerup");
    frame(0, 0, 0, 1, 1, 2'd3, 0, 0, 0, 1, "gain");
    frame(0, 0, 0, 1, 1, 2'd3, 0, 0, 0, 1, "gain_saturate");

    frame(0, 0, 1, 0, 0, 2'd2, 0, 1, 1, eb(0), "hit2");
    frame(0, 0, 0, 1, 1, 2'd3, 0, 1, 0, eb(1), "gain_in_window");
    frame(0, 0, 0, 1, 1, 2'd3, 0, 1, 0, eb(2), "saturate_in_window");
    frame(0, 1, 0, 0, 0, 2'd3, 0, 0, 0, 1, "reset_mid_window");
    frame(0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 1, "after_reset");

    frame(0, 0, 1, 0, 0, 2'd2, 0, 1, 1, eb(0), "hit3");
    win(1, 59, 0, 1, 0, 2'd2, "window_no_powerup");
    frame(0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 1, "window_end2");

    frame(0, 0, 1, 1, 1, 2'd1, 0, 1, 1, eb(0), "lose_beats_gain");
    win(1, 59, 0, 0, 0, 2'd1, "window3");
    frame(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1, "window_end3");

    frame(0, 0, 1, 0, 0, 2'd0, 1, 0, 1, 1, "last_life");
    frame(0, 0, 0, 1, 1, 2'd0, 1, 0, 0, 1, "game_over_gain");
    frame(0, 0, 1, 0, 0, 2'd0, 1, 0, 0, 1, "game_over_lose");
    frame(0, 1, 0, 0, 0, 2'd3, 0, 0, 0, 1, "reset_game_over");
    frame(0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 1, "idle_after_go");

    frame(1, 0, 1, 0, 0, 2'd2, 0, 0, 1, 1, "nowin_hit1");
    frame(1, 0, 1, 0, 0, 2'd1, 0, 0, 1, 1, "nowin_hit2");
    frame(1, 0, 1, 0, 0, 2'd0, 1, 0, 1, 1, "nowin_hit3");
    frame(1, 0, 0, 1, 1, 2'd0, 1, 0, 0, 1, "nowin_game_over");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
